// File: rtl/data_mem_responder_if.sv
// Request/response bus between the pipeline MEM stage (master) and the data memory
// responder (slave).
interface data_mem_responder_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       resp_valid;
  logic [7:0] resp_rdata;
  logic       resp_err;
  logic       busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder: IDLE -> (WAIT) -> RESP -> IDLE.
// Define DMEM_WAIT_EN to insert WAIT_CYCLES wait states per access.
module data_mem_responder #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic                  clk,
  input logic                  reset,
  data_mem_responder_if.slave  dmem_io
);

  localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0]  DepthW = 9'(DEPTH);

  if (DEPTH < 1 || DEPTH > 256) begin : g_bad_depth
    $error("DEPTH must be in 1..256");
  end
  if (WAIT_CYCLES > 15) begin : g_bad_wait
    $error("WAIT_CYCLES must be in 0..15");
  end

`ifdef DMEM_WAIT_EN
  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;
`else
  typedef enum logic [0:0] {StIdle, StResp} state_e;
`endif

  state_e     state_q, state_d;
  logic [7:0] rdata_q;
  logic       err_q;
  logic [7:0] mem_q [2**AW];

  logic       accept;
  logic       acc_we;
  logic [7:0] acc_addr;
  logic [7:0] acc_wdata;
  logic       acc_err;
  logic       commit;
  logic       mem_wr;
  logic [AW-1:0] mem_idx;

  assign accept = dmem_io.req_valid && (state_q == StIdle);

`ifdef DMEM_WAIT_EN
  logic [3:0] cnt_q, cnt_d;
  logic       we_q;
  logic [7:0] addr_q, wdata_q;

  // The access completes either on the acceptance edge (live inputs) or out of WAIT (captured).
  assign acc_we    = (state_q == StIdle) ? dmem_io.req_we    : we_q;
  assign acc_addr  = (state_q == StIdle) ? dmem_io.req_addr  : addr_q;
  assign acc_wdata = (state_q == StIdle) ? dmem_io.req_wdata : wdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
    end else begin
      cnt_q <= cnt_d;
      if (accept) begin
        we_q    <= dmem_io.req_we;
        addr_q  <= dmem_io.req_addr;
        wdata_q <= dmem_io.req_wdata;
      end
    end
  end
`else
  assign acc_we    = dmem_io.req_we;
  assign acc_addr  = dmem_io.req_addr;
  assign acc_wdata = dmem_io.req_wdata;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end
`endif

  assign acc_err = {1'b0, acc_addr} >= DepthW;
  assign commit  = (state_d == StResp) && (state_q != StResp);
  assign mem_wr  = commit && acc_we && !acc_err;
  assign mem_idx = acc_addr[AW-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      rdata_q <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (commit) begin
        err_q   <= acc_err;
        rdata_q <= (acc_we || acc_err) ? 8'h00 : mem_q[mem_idx];
      end
    end
  end

  // Contents have no reset value; reset only blocks writes while it is asserted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
    end else if (mem_wr) begin
      mem_q[mem_idx] <= acc_wdata;
    end
  end

  assign dmem_io.req_ready  = (state_q == StIdle);
  assign dmem_io.resp_valid = (state_q == StResp);
  assign dmem_io.resp_rdata = (state_q == StResp) ? rdata_q : 8'h00;
  assign dmem_io.resp_err   = (state_q == StResp) && err_q;
  assign dmem_io.busy       = (state_q != StIdle) || dmem_io.req_valid;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder (DEPTH=128); expected latency follows DMEM_WAIT_EN.
module tb_data_mem_responder;

  localparam int unsigned Depth = 128;
  localparam int unsigned Wait  = 2;
`ifdef DMEM_WAIT_EN
  localparam int unsigned Extra = Wait;
`else
  localparam int unsigned Extra = 0;
`endif

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    logic       exp_err;
  } vec_t;

  typedef struct packed {
    logic [7:0]  rdata;
    logic        err;
    logic [31:0] cyc;
  } exp_t;

  logic        clk;
  logic        reset;
  int unsigned cyc;
  int          checks;
  int          errors;
  exp_t        sb[$];
  exp_t        mon_e;
  vec_t        tbl [12];
  int unsigned acc_c [4];
  int unsigned tmp_c;

  data_mem_responder_if bus ();

  data_mem_responder #(
    .DEPTH       (Depth),
    .WAIT_CYCLES (Wait)
  ) u_dut (
    .clk     (clk),
    .reset   (reset),
    .dmem_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] pattern(input int unsigned i);
    return 8'(i) ^ 8'hC3;
  endfunction

  // Present one access; push its expected response once acceptance is certain.
  task automatic access(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                        input logic [7:0] exp_rdata, input logic exp_err, input bit hold,
                        output int unsigned acc_cyc);
    int guard;
    acc_cyc = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    guard = 0;
    while (!bus.req_ready && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", 32'(bus.req_ready), 32'd1);
    if (!bus.req_ready) begin
      bus.req_valid = 1'b0;
      return;
    end
    acc_cyc = cyc + 1;
    sb.push_back('{rdata: exp_rdata, err: exp_err, cyc: acc_cyc + Extra});
    @(posedge clk);
    #1;
    if (!hold) bus.req_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.resp_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("resp_rdata", 32'(bus.resp_rdata), 32'(mon_e.rdata));
          check("resp_err", 32'(bus.resp_err), 32'(mon_e.err));
          check("resp_latency", cyc, mon_e.cyc);
        end
      end else begin
        check("idle_rdata", 32'(bus.resp_rdata), 32'd0);
        check("idle_err", 32'(bus.resp_err), 32'd0);
      end
    end
  end

  initial begin
    int guard;
    checks = 0;
    errors = 0;
    tbl[0]  = '{1'b1, 8'h10, 8'hA5, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 8'h10, 8'h00, 8'hA5, 1'b0};
    tbl[2]  = '{1'b1, 8'h80, 8'h55, 8'h00, 1'b1};
    tbl[3]  = '{1'b0, 8'h00, 8'h00, 8'hC3, 1'b0};
    tbl[4]  = '{1'b0, 8'h80, 8'h00, 8'h00, 1'b1};
    tbl[5]  = '{1'b0, 8'h7F, 8'h00, 8'hBC, 1'b0};
    tbl[6]  = '{1'b1, 8'h7F, 8'h01, 8'h00, 1'b0};
    tbl[7]  = '{1'b0, 8'h7F, 8'h00, 8'h01, 1'b0};
    tbl[8]  = '{1'b0, 8'hFF, 8'h00, 8'h00, 1'b1};
    tbl[9]  = '{1'b1, 8'hFF, 8'h99, 8'h00, 1'b1};
    tbl[10] = '{1'b0, 8'h20, 8'h00, 8'hE3, 1'b0};
    tbl[11] = '{1'b0, 8'h10, 8'h00, 8'hA5, 1'b0};

    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 8'h00;
    bus.req_wdata = 8'h00;

    // Reset state, including busy tracking req_valid.
    @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_rdata", 32'(bus.resp_rdata), 32'd0);
    check("rst_err", 32'(bus.resp_err), 32'd0);
    check("rst_busy0", 32'(bus.busy), 32'd0);
    bus.req_valid = 1'b1;
    #1;
    check("rst_busy1", 32'(bus.busy), 32'd1);
    bus.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < int'(Depth); i++) begin
      access(1'b1, 8'(i), pattern(i), 8'h00, 1'b0, 1'b0, tmp_c);
    end

    for (int i = 0; i < 12; i++) begin
      access(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata, tbl[i].exp_err,
             1'b0, tmp_c);
    end

    // req_ready low and busy high for the whole access.
    access(1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, 1'b0, tmp_c);
    for (int n = 0; n <= int'(Extra); n++) begin
      @(negedge clk);
      check("inflight_ready", 32'(bus.req_ready), 32'd0);
      check("inflight_busy", 32'(bus.busy), 32'd1);
    end
    @(negedge clk);
    check("after_ready", 32'(bus.req_ready), 32'd1);
    check("after_busy", 32'(bus.busy), 32'd0);

    // Back-to-back writes with req_valid held high.
    for (int i = 0; i < 4; i++) begin
      access(1'b1, 8'(i), 8'hB0 + 8'(i), 8'h00, 1'b0, (i != 3), acc_c[i]);
    end
    for (int i = 1; i < 4; i++) begin
      check("b2b_spacing", acc_c[i] - acc_c[i-1], Extra + 2);
    end
    for (int i = 0; i < 4; i++) begin
      access(1'b0, 8'(i), 8'h00, 8'hB0 + 8'(i), 1'b0, 1'b0, tmp_c);
    end

    // Inputs changed after a write is accepted must not reach memory.
    access(1'b1, 8'h05, 8'h3C, 8'h00, 1'b0, 1'b0, tmp_c);
    bus.req_addr  = 8'h06;
    bus.req_wdata = 8'hFF;
    bus.req_we    = 1'b1;
    access(1'b0, 8'h05, 8'h00, 8'h3C, 1'b0, 1'b0, tmp_c);
    access(1'b0, 8'h06, 8'h00, 8'hC5, 1'b0, 1'b0, tmp_c);

    // Reset pulse: aborts an access in WAIT; memory contents survive.
    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 8'h20;
    bus.req_wdata = 8'h77;
`ifdef DMEM_WAIT_EN
    check("abort_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
`else
    @(negedge clk);
    bus.req_valid = 1'b0;
`endif
    reset = 1'b1;
    #1;
    check("abort_valid", 32'(bus.resp_valid), 32'd0);
    check("abort_ready_rst", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_idle", 32'(bus.req_ready), 32'd1);
`ifdef DMEM_WAIT_EN
    access(1'b0, 8'h20, 8'h00, 8'hE3, 1'b0, 1'b0, tmp_c);
`else
    access(1'b0, 8'h20, 8'h00, 8'h77, 1'b0, 1'b0, tmp_c);
`endif
    access(1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, 1'b0, tmp_c);

    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 256, number of 8-bit data memory words; legal range 1..256.
REQ-002 Parameter WAIT_CYCLES, default 2, number of wait states inserted per access when DMEM_WAIT_EN is defined; legal range 0..15.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  1  pipeline MEM stage presents an access.
REQ-006 req_ready  output  1  responder can accept an access this cycle.
REQ-007 req_we  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  8  word address.
REQ-009 req_wdata  input  8  store data.
REQ-010 resp_valid  output  1  one-cycle pulse: access complete.
REQ-011 resp_rdata  output  8  load data, valid only while resp_valid=1.
REQ-012 resp_err  output  1  address out of range, valid only while resp_valid=1.
REQ-013 busy  output  1  access in flight; drives pipeline stall.

Function
REQ-014 FSM states: IDLE, WAIT, RESP; IDLE is the only state with req_ready=1.
REQ-015 Acceptance occurs on a rising edge with req_valid=1 and req_ready=1; req_we, req_addr and req_wdata are captured into internal registers at that edge and ignored thereafter until the next acceptance.
REQ-016 IDLE -> RESP on acceptance when the wait feature is absent or WAIT_CYCLES=0; IDLE -> WAIT on acceptance otherwise, with the wait counter loaded to WAIT_CYCLES-1.
REQ-017 WAIT: counter decrements each cycle; WAIT -> RESP on the edge where the counter is 0.
REQ-018 Memory write and read-data capture occur on the edge entering RESP, using the captured address and data.
REQ-019 RESP lasts exactly one cycle with resp_valid=1, then RESP -> IDLE unconditionally; there is no response backpressure.
REQ-020 Latency: resp_valid is high in the cycle following the acceptance edge plus WAIT_CYCLES cycles; minimum throughput one access per 2 cycles.
REQ-021 busy=1 in WAIT and RESP, and also in IDLE when req_valid=1; busy=0 otherwise.
REQ-022 Read: resp_rdata = mem[addr]; write: resp_rdata = 8'h00.
REQ-023 Address >= DEPTH: resp_err=1, resp_rdata=8'h00, write dropped, memory unchanged; otherwise resp_err=0.
REQ-024 When resp_valid=0, resp_rdata=8'h00 and resp_err=0.
REQ-025 A read of an address written by the immediately preceding access returns the new data.

Reset
REQ-026 Asserting reset forces state to IDLE, clears the wait counter, and sets resp_valid=0, resp_rdata=8'h00, resp_err=0 and busy to req_valid.
REQ-027 Reset asserted during WAIT aborts the access; a pending write is not committed.
REQ-028 Memory array contents are not affected by reset.

Configuration
REQ-029 Macro DMEM_WAIT_EN: when defined, the WAIT state and its 4-bit counter are compiled in and WAIT_CYCLES applies.
REQ-030 When DMEM_WAIT_EN is undefined, the WAIT state and counter are absent, WAIT_CYCLES is ignored, and latency is fixed at 1 cycle.

Verification
REQ-031 No macro: write addr 8'h10 data 8'hA5, then read 8'h10 -> each resp_valid is 1 cycle after acceptance; read resp_rdata=8'hA5, resp_err=0.
REQ-032 DMEM_WAIT_EN with WAIT_CYCLES=2: read 8'h10 -> resp_valid 3 cycles after acceptance, req_ready=0 and busy=1 throughout.
REQ-033 DEPTH=128: write 8'h80 data 8'h55 -> resp_err=1; read 8'h00 unchanged; read 8'h80 -> resp_rdata=8'h00, resp_err=1.
REQ-034 req_valid held high for 4 back-to-back writes to 8'h00..8'h03 (no macro) -> exactly 4 acceptances on alternate cycles, all 4 words written.
REQ-035 DMEM_WAIT_EN, WAIT_CYCLES=3: write 8'h20 data 8'h77, reset asserted in the second WAIT cycle -> no resp_valid; state IDLE; subsequent read of 8'h20 returns its prior value.
REQ-036 Changing req_addr and req_wdata during WAIT after accepting a write to 8'h05 data 8'h3C -> mem[8'h05]=8'h3C.
